// File: rtl/addr8s_tr_pkg.sv
// addr8s_tr_pkg: shared constants for the time-redundant adder controller.
//   - Default operand width and event-counter width.
//   - FSM state encodings, kept as plain constants for legacy tool flows.
//   - Vote outcome encodings.
package addr8s_tr_pkg;

  localparam int unsigned DefW    = 8;
  localparam int unsigned DefCntW = 8;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StP1   = 3'd1;
  localparam logic [2:0] StP2   = 3'd2;
  localparam logic [2:0] StP3   = 3'd3;
  localparam logic [2:0] StDone = 3'd4;

  localparam logic [1:0] OcClean = 2'd0;
  localparam logic [1:0] OcCorr  = 2'd1;
  localparam logic [1:0] OcErr   = 2'd2;

endpackage

// File: rtl/addr8s_vote3.sv
// addr8s_vote3: combinational 2-of-3 voter over three W+1-bit adder results.
// Ports:
//   r1, r2, r3  in   results of pass 1, 2, 3
//   result      out  voted result (r1 when no majority exists)
//   corr        out  passes disagreed and a majority resolved the result
//   err         out  no two passes agree
module addr8s_vote3
  import addr8s_tr_pkg::*;
#(
  parameter int unsigned W = DefW
) (
  input  logic [W:0] r1,
  input  logic [W:0] r2,
  input  logic [W:0] r3,
  output logic [W:0] result,
  output logic       corr,
  output logic       err
);

  logic [1:0] outcome;

  always_comb begin
    outcome = OcClean;
    result  = r1;
    if (r1 == r2) begin
      outcome = OcClean;
    end else if (r3 == r1) begin
      outcome = OcCorr;
    end else if (r3 == r2) begin
      outcome = OcCorr;
      result  = r2;
    end else begin
      outcome = OcErr;
    end
  end

  assign corr = (outcome == OcCorr);
  assign err  = (outcome == OcErr);

endmodule

// File: rtl/addr8s_tr_ctrl.sv
// addr8s_tr_ctrl: time-redundant execution controller for one shared
// combinational signed adder. Each operand pair is added twice; on mismatch a
// third pass is run and the three results are voted.
// Build option: define ADDR8S_TR_SWAP_EN to swap operands on pass 2.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   in_valid/in_ready      operand handshake (ready only in IDLE)
//   in_a, in_b             signed operands
//   add_a, add_b, add_sum  shared adder interface
//   out_valid/out_ready    result handshake, held until accepted
//   out_sum/corr/err       voted sum and outcome flags
//   corr_cnt, err_cnt      saturating event counters
//   cnt_clr                synchronous counter clear (wins over increment)
module addr8s_tr_ctrl
  import addr8s_tr_pkg::*;
#(
  parameter int unsigned W     = DefW,
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  output logic [W-1:0]     add_a,
  output logic [W-1:0]     add_b,
  input  logic [W:0]       add_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W:0]       out_sum,
  output logic             out_corr,
  output logic             out_err,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             cnt_clr
);

  logic [2:0]       state_q, state_d;
  logic [W-1:0]     op_a_q, op_a_d, op_b_q, op_b_d;
  logic [W:0]       r1_q, r1_d, r2_q, r2_d, sum_q, sum_d;
  logic             corr_q, corr_d, err_q, err_d;
  logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d, err_cnt_q, err_cnt_d;

  logic [W:0] vote_result;
  logic       vote_corr, vote_err;
  logic       p2_swap;

  // Pass 3 votes on the live adder output so the result lands with the DONE entry.
  addr8s_vote3 #(
    .W (W)
  ) u_vote (
    .r1     (r1_q),
    .r2     (r2_q),
    .r3     (add_sum),
    .result (vote_result),
    .corr   (vote_corr),
    .err    (vote_err)
  );

`ifdef ADDR8S_TR_SWAP_EN
  assign p2_swap = (state_q == StP2);
`else
  assign p2_swap = 1'b0;
`endif

  // Latched operands stay on the adder outside the passes to avoid toggling.
  assign add_a     = p2_swap ? op_b_q : op_a_q;
  assign add_b     = p2_swap ? op_a_q : op_b_q;
  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign out_sum   = sum_q;
  assign out_corr  = corr_q;
  assign out_err   = err_q;
  assign corr_cnt  = corr_cnt_q;
  assign err_cnt   = err_cnt_q;

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    sum_d   = sum_q;
    corr_d  = corr_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_a_d  = in_a;
          op_b_d  = in_b;
          state_d = StP1;
        end
      end
      StP1: begin
        r1_d    = add_sum;
        state_d = StP2;
      end
      StP2: begin
        r2_d = add_sum;
        if (add_sum == r1_q) begin
          sum_d   = r1_q;
          corr_d  = 1'b0;
          err_d   = 1'b0;
          state_d = StDone;
        end else begin
          state_d = StP3;
        end
      end
      StP3: begin
        sum_d   = vote_result;
        corr_d  = vote_corr;
        err_d   = vote_err;
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Counters bump on the edge that enters DONE; only pass 3 can flag events.
  always_comb begin
    corr_cnt_d = corr_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (cnt_clr) begin
      corr_cnt_d = '0;
      err_cnt_d  = '0;
    end else if (state_q == StP3) begin
      if (vote_corr && (corr_cnt_q != '1)) corr_cnt_d = corr_cnt_q + 1'b1;
      if (vote_err && (err_cnt_q != '1))   err_cnt_d  = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      op_a_q     <= '0;
      op_b_q     <= '0;
      r1_q       <= '0;
      r2_q       <= '0;
      sum_q      <= '0;
      corr_q     <= 1'b0;
      err_q      <= 1'b0;
      corr_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      r1_q       <= r1_d;
      r2_q       <= r2_d;
      sum_q      <= sum_d;
      corr_q     <= corr_d;
      err_q      <= err_d;
      corr_cnt_q <= corr_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

endmodule
